// File: rtl/hs_cdc_gray_ptr_src.sv
// Launch-side gray pointer: queues increment bursts, advances one step per clock.
// gray_out is registered and moves at most one bit per clock, so it may cross domains.
module hs_cdc_gray_ptr_src #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4,
   parameter int PEND_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  areset,
   input  logic                  step_valid,
   output logic                  step_ready,
   input  logic [STEP_WIDTH-1:0] step_num,
   output logic [WIDTH-1:0]      bin_out,
   output logic [WIDTH-1:0]      gray_out,
   output logic [PEND_WIDTH-1:0] pending,
   output logic                  idle
);

   localparam int PW = PEND_WIDTH + 1;

   localparam logic [PW-1:0] PMAX =
      {1'b0, {PEND_WIDTH{1'b1}}};
   localparam logic [PW-1:0] SMAX =
      {{(PW-STEP_WIDTH){1'b0}}, {STEP_WIDTH{1'b1}}};
   localparam logic [PW-1:0] THRESH = PMAX - SMAX;

   if (PEND_WIDTH <= STEP_WIDTH) begin : g_bad_pend
      $error("PEND_WIDTH must exceed STEP_WIDTH");
   end

   logic          drain;
   logic          acc;
   logic [PW-1:0] pend_ext;
   logic [PW-1:0] add_ext;
   logic [PW-1:0] pend_nx;
   logic [WIDTH-1:0] bin_nx;

   // Admit a request only if a full-size burst still fits in the queue.
   assign pend_ext   = {1'b0, pending};
   assign step_ready = !areset && (pend_ext <= THRESH);
   assign drain      = (pending != '0);
   assign acc        = step_valid && step_ready;
   assign idle       = (pending == '0);

   assign add_ext = acc ? {{(PW-STEP_WIDTH){1'b0}}, step_num}
                        : '0;
   assign pend_nx = pend_ext + add_ext
                  - {{PEND_WIDTH{1'b0}}, drain};
   assign bin_nx  = bin_out + {{(WIDTH-1){1'b0}}, drain};

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         pending  <= '0;
         bin_out  <= '0;
         gray_out <= '0;
      end else begin
         pending  <= pend_nx[PEND_WIDTH-1:0];
         bin_out  <= bin_nx;
         gray_out <= bin_nx ^ (bin_nx >> 1);
      end
   end

`ifndef SYNTHESIS
   logic [WIDTH-1:0] gray_prev;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) gray_prev <= '0;
      else        gray_prev <= gray_out;
   end

   a_gray_one_bit: assert property (
      @(posedge clk) disable iff (areset)
      $countones(gray_out ^ gray_prev) <= 1);

   a_pend_max: assert property (
      @(posedge clk) disable iff (areset)
      pend_nx <= PMAX);

   a_req_hold: assert property (
      @(posedge clk) disable iff (areset)
      (step_valid && !step_ready)
      |=> (step_valid && $stable(step_num)));
`endif

endmodule

// File: tb/tb_hs_cdc_gray_ptr_src.sv
// Bench for hs_cdc_gray_ptr_src: directed plan plus constrained-random traffic.
// Reference keeps a pending count and an integer pointer; gray comes from a lookup table.
module tb_hs_cdc_gray_ptr_src;

   logic       clk = 1'b0;
   logic       areset = 1'b1;
   logic       step_valid = 1'b0;
   logic       step_ready;
   logic [3:0] step_num = '0;
   logic [2:0] bin_out;
   logic [2:0] gray_out;
   logic [4:0] pending;
   logic       idle;

   hs_cdc_gray_ptr_src #(
      .WIDTH(3), .STEP_WIDTH(4), .PEND_WIDTH(5)
   ) dut (
      .clk(clk),
      .areset(areset),
      .step_valid(step_valid),
      .step_ready(step_ready),
      .step_num(step_num),
      .bin_out(bin_out),
      .gray_out(gray_out),
      .pending(pending),
      .idle(idle)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int m_pend = 0;
   int m_ptr = 0;
   logic [2:0] gtab [8] = '{3'd0, 3'd1, 3'd3, 3'd2,
                            3'd6, 3'd7, 3'd5, 3'd4};
   logic last_acc;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_pend"}, 32'(pending), 32'(m_pend));
      check({tag, "_bin"}, 32'(bin_out), 32'(m_ptr));
      check({tag, "_gray"}, 32'(gray_out), 32'(gtab[m_ptr]));
      check({tag, "_idle"}, 32'(idle), 32'(m_pend == 0));
   endtask

   // Called #1 after a rising edge; returns #1 after the next one.
   task automatic step(input logic v, input logic [3:0] n);
      logic rdy;
      logic [2:0] g_prev;
      step_valid = v;
      step_num   = n;
      #1;
      rdy = (m_pend <= 16);
      check("ready", 32'(step_ready), 32'(rdy));
      g_prev = gray_out;
      last_acc = v && rdy;
      if (m_pend > 0) begin
         m_pend--;
         m_ptr = (m_ptr + 1) % 8;
      end
      if (last_acc) m_pend += int'(n);
      @(posedge clk);
      #1;
      check_state("step");
      check("gray_1bit",
            32'($countones(gray_out ^ g_prev) <= 1), 32'd1);
   endtask

   // Asynchronous assert mid-cycle, release just after an edge.
   task automatic do_reset();
      #3;
      areset = 1'b1;
      step_valid = 1'b0;
      step_num = '0;
      #1;
      m_pend = 0;
      m_ptr = 0;
      check_state("rst");
      check("rst_ready", 32'(step_ready), 32'd0);
      @(posedge clk);
      #1;
      areset = 1'b0;
   endtask

   initial begin
      logic hv;
      logic [3:0] hn;
      logic held;

      @(posedge clk);
      @(posedge clk);
      #1;
      check_state("por");
      check("por_ready", 32'(step_ready), 32'd0);
      areset = 1'b0;

      // 1: single increment
      step(1'b1, 4'd1);
      check("t1_pend", 32'(pending), 32'd1);
      step(1'b0, 4'd0);
      check("t1_bin", 32'(bin_out), 32'd1);
      check("t1_gray", 32'(gray_out), 32'b001);
      check("t1_idle", 32'(idle), 32'd1);

      // 2: burst of 5
      do_reset();
      step(1'b1, 4'd5);
      for (int i = 0; i < 5; i++) step(1'b0, 4'd0);
      check("t2_bin", 32'(bin_out), 32'd5);
      check("t2_gray", 32'(gray_out), 32'b111);

      // 3: wrap through 7 -> 0
      do_reset();
      step(1'b1, 4'd10);
      for (int i = 0; i < 10; i++) step(1'b0, 4'd0);
      check("t3_bin", 32'(bin_out), 32'd2);
      check("t3_gray", 32'(gray_out), 32'b011);
      check("t3_pend", 32'(pending), 32'd0);

      // 4: backpressure with held request
      do_reset();
      step(1'b1, 4'd15);
      check("t4_p15", 32'(pending), 32'd15);
      step(1'b1, 4'd15);
      check("t4_p29", 32'(pending), 32'd29);
      for (int i = 0; i < 13; i++) step(1'b1, 4'd15);
      check("t4_p16", 32'(pending), 32'd16);
      step(1'b1, 4'd15);
      check("t4_p30", 32'(pending), 32'd30);
      for (int i = 0; i < 30; i++) step(1'b0, 4'd0);

      // 5: accept and drain on the same edge, zero step
      do_reset();
      step(1'b1, 4'd3);
      step(1'b1, 4'd2);
      check("t5_pend", 32'(pending), 32'd4);
      check("t5_bin", 32'(bin_out), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd0);
      step(1'b1, 4'd0);
      check("t5_zpend", 32'(pending), 32'd0);
      check("t5_zbin", 32'(bin_out), 32'd5);

      // 6: async reset with work queued
      do_reset();
      step(1'b1, 4'd5);
      for (int i = 0; i < 4; i++) step(1'b0, 4'd0);
      step(1'b1, 4'd7);
      check("t6_pend", 32'(pending), 32'd7);
      check("t6_bin", 32'(bin_out), 32'd5);
      do_reset();
      step(1'b1, 4'd1);
      step(1'b0, 4'd0);
      check("t6_bin1", 32'(bin_out), 32'd1);

      // Random traffic; a refused request is held until accepted
      held = 1'b0;
      hv = 1'b0;
      hn = '0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset();
            held = 1'b0;
         end
         if (!held) begin
            hv = ($urandom_range(0, 1) == 1);
            hn = 4'($urandom_range(0, 15));
         end
         step(hv, hn);
         held = hv && !last_acc;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
